pwm_gen: RTL and testbench

- Single-channel PWM generator with a programmable period and a programmable duty cycle.
- Driven by the PWM clock domain; sits between the control/register logic and the output pin.
- Period and duty are loaded by strobes; the duty can also be stepped up or down.
- Duty changes take effect at period boundaries, so no glitches or runt pulses appear on the output.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_gen_duty_ctrl.sv | 66 ++++++
 rtl/pwm_gen.sv | 122 ++++++++++++
 tb/tb_pwm_gen.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and types for the PWM generator.
//   PWM_WIDTH : default bit width of period, duty and counter
//   PWM_STEP  : default duty step applied per up/down strobe
//   pwm_cnt_t : count/duty value at the default width
package pwm_pkg;

  localparam int unsigned PWM_WIDTH = 10;
  localparam int unsigned PWM_STEP  = 1;

  typedef logic [PWM_WIDTH-1:0] pwm_cnt_t;

endpackage

// File: rtl/pwm_gen_duty_ctrl.sv
// Duty shadow register for the PWM generator: applies the per-clock control
// priority (load > update > up/down) with saturating step arithmetic.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   i_initial_update        load i_initial_duty (highest priority)
//   i_initial_duty          duty value loaded by i_initial_update
//   i_duty_update           load i_duty
//   i_duty                  duty value loaded by i_duty_update
//   i_up, i_down            step shadow by STEP (both together: no change)
//   i_period                current period, upper bound for stepping up
//   o_duty_shadow           registered shadow duty
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH,
  parameter int unsigned STEP  = PWM_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_initial_update,
  input  logic [WIDTH-1:0] i_initial_duty,
  input  logic             i_duty_update,
  input  logic [WIDTH-1:0] i_duty,
  input  logic             i_up,
  input  logic             i_down,
  input  logic [WIDTH-1:0] i_period,
  output logic [WIDTH-1:0] o_duty_shadow
);

  // One extra bit so step results never wrap
  localparam int unsigned EW = WIDTH + 1;

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic [EW-1:0]    w_up_sum;
  logic             w_dn_under;

  assign w_up_sum   = {1'b0, r_shadow} + EW'(STEP);
  assign w_dn_under = ({1'b0, r_shadow} < EW'(STEP));

  // Control priority and saturation
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (i_initial_update) begin
      w_shadow_nxt = i_initial_duty;
    end else if (i_duty_update) begin
      w_shadow_nxt = i_duty;
    end else if (i_up && !i_down) begin
      w_shadow_nxt = (w_up_sum > {1'b0, i_period}) ? i_period : w_up_sum[WIDTH-1:0];
    end else if (i_down && !i_up) begin
      w_shadow_nxt = w_dn_under ? '0 : (r_shadow - WIDTH'(STEP));
    end
  end

  // Shadow register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else begin
      r_shadow <= w_shadow_nxt;
    end
  end

  assign o_duty_shadow = r_shadow;

endmodule

// File: rtl/pwm_gen.sv
// Single-channel PWM generator with programmable period and duty. Duty
// changes from the shadow register are applied only at period wrap, so the
// output never shows runt pulses.
// Optional feature: define PWM_COMPL_EN to add the complementary output pwm_n.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   pwm_en                  run enable (level)
//   initial_cycle           period in clocks, loaded by initial_update
//   initial_duty_cycle      duty in clocks, loaded by initial_update
//   initial_update          strobe: load period and duty, restart counter
//   duty_cycle              new duty, staged by duty_cycle_update
//   duty_cycle_update       strobe: stage duty_cycle
//   up, down                strobes: step staged duty by STEP
//   pwm                     registered PWM output
//   period_end              registered pulse marking the last output clock of a period
//   pwm_n                   (PWM_COMPL_EN) registered complement while running
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH,
  parameter int unsigned STEP  = PWM_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_en,
  input  logic [WIDTH-1:0] initial_cycle,
  input  logic [WIDTH-1:0] initial_duty_cycle,
  input  logic             initial_update,
  input  logic [WIDTH-1:0] duty_cycle,
  input  logic             duty_cycle_update,
  input  logic             up,
  input  logic             down,
  output logic             pwm,
`ifdef PWM_COMPL_EN
  output logic             pwm_n,
`endif
  output logic             period_end
);

  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_duty_active;
  logic [WIDTH-1:0] r_cnt;
  logic             r_pwm;
  logic             r_period_end;
  logic [WIDTH-1:0] w_duty_shadow;
  logic             w_run;
  logic             w_last;
  logic             w_hi;

  pwm_duty_ctrl #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_duty_ctrl (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_initial_update (initial_update),
    .i_initial_duty   (initial_duty_cycle),
    .i_duty_update    (duty_cycle_update),
    .i_duty           (duty_cycle),
    .i_up             (up),
    .i_down           (down),
    .i_period         (r_period),
    .o_duty_shadow    (w_duty_shadow)
  );

  assign w_run  = pwm_en && (r_period != '0);
  // >= rather than == keeps the wrap safe even if cnt were ever past the end
  assign w_last = (r_cnt >= (r_period - WIDTH'(1)));
  assign w_hi   = (r_cnt < r_duty_active);

  // Period/duty load, counter and duty hand-over at wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_period      <= '0;
      r_duty_active <= '0;
      r_cnt         <= '0;
    end else if (initial_update) begin
      r_period      <= initial_cycle;
      r_duty_active <= initial_duty_cycle;
      r_cnt         <= '0;
    end else if (w_run) begin
      if (w_last) begin
        r_cnt         <= '0;
        r_duty_active <= w_duty_shadow;
      end else begin
        r_cnt <= r_cnt + WIDTH'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Outputs share one register stage so period_end lines up with the pwm slot it marks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm        <= 1'b0;
      r_period_end <= 1'b0;
    end else begin
      r_pwm        <= w_run && w_hi;
      r_period_end <= w_run && w_last;
    end
  end

  assign pwm        = r_pwm;
  assign period_end = r_period_end;

`ifdef PWM_COMPL_EN
  logic r_pwm_n;

  // Complement only while running; idle level is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm_n <= 1'b0;
    end else begin
      r_pwm_n <= w_run && !w_hi;
    end
  end

  assign pwm_n = r_pwm_n;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: expected per-period (high clocks, length)
// pairs are queued as stimulus is driven and checked at each period_end.
module tb_pwm_gen;
  import pwm_pkg::*;

  localparam int unsigned W = PWM_WIDTH;

  typedef struct {
    int hi;
    int len;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pwm_en;
  logic [W-1:0] initial_cycle;
  logic [W-1:0] initial_duty_cycle;
  logic         initial_update;
  logic [W-1:0] duty_cycle;
  logic         duty_cycle_update;
  logic         up;
  logic         down;
  logic         pwm;
  logic         period_end;
`ifdef PWM_COMPL_EN
  logic         pwm_n;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  bit   mon_on = 1'b0;
  int   hi_cnt = 0;
  int   len_cnt = 0;

  always #5 clk = ~clk;

  pwm_gen dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pwm_en             (pwm_en),
    .initial_cycle      (initial_cycle),
    .initial_duty_cycle (initial_duty_cycle),
    .initial_update     (initial_update),
    .duty_cycle         (duty_cycle),
    .duty_cycle_update  (duty_cycle_update),
    .up                 (up),
    .down               (down),
    .pwm                (pwm),
`ifdef PWM_COMPL_EN
    .pwm_n              (pwm_n),
`endif
    .period_end         (period_end)
  );

  // One clock: sample at negedge, scoreboard check on period_end
  task automatic step();
    @(negedge clk);
    if (mon_on) begin
      if (pwm === 1'b1) hi_cnt++;
      len_cnt++;
`ifdef PWM_COMPL_EN
      total++;
      if (pwm_n !== ~pwm) begin
        bad++;
        $display("FAIL pwm_n_compl: got %b want %b", pwm_n, ~pwm);
      end
`endif
      if (period_end === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_period_end: hi=%0d len=%0d, no period expected", hi_cnt, len_cnt);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (hi_cnt !== e.hi) begin
            bad++;
            $display("FAIL period_high: got %0d want %0d", hi_cnt, e.hi);
          end
          total++;
          if (len_cnt !== e.len) begin
            bad++;
            $display("FAIL period_len: got %0d want %0d", len_cnt, e.len);
          end
        end
        hi_cnt  = 0;
        len_cnt = 0;
      end
    end
  endtask

  task automatic push(input int hi, input int len);
    exp_t e;
    e.hi  = hi;
    e.len = len;
    exp_q.push_back(e);
  endtask

  // Run until every queued period has been observed, within a cycle budget
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d periods pending after %0d clocks", exp_q.size(), budget);
    end
    exp_q.delete();
  endtask

  task automatic load(input pwm_cnt_t per, input pwm_cnt_t duty);
    initial_cycle      = per;
    initial_duty_cycle = duty;
    initial_update     = 1'b1;
    step();
    initial_update     = 1'b0;
  endtask

  task automatic start_run();
    hi_cnt  = 0;
    len_cnt = 0;
    pwm_en  = 1'b1;
    mon_on  = 1'b1;
  endtask

  task automatic stop_run();
    mon_on = 1'b0;
    pwm_en = 1'b0;
    step();
  endtask

  task automatic pulse_up_down(input logic u, input logic d);
    up   = u;
    down = d;
    step();
    up   = 1'b0;
    down = 1'b0;
  endtask

  task automatic check_idle(input string name);
    total++;
    if (pwm !== 1'b0 || period_end !== 1'b0) begin
      bad++;
      $display("FAIL %s: pwm=%b period_end=%b want 0/0", name, pwm, period_end);
    end
`ifdef PWM_COMPL_EN
    total++;
    if (pwm_n !== 1'b0) begin
      bad++;
      $display("FAIL %s_pwm_n: got %b want 0", name, pwm_n);
    end
`endif
  endtask

  // Count any activity over n clocks; a zero period must keep everything low
  task automatic check_quiet(input string name, input int n);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (pwm !== 1'b0 || period_end !== 1'b0) act++;
    end
    total++;
    if (act != 0) begin
      bad++;
      $display("FAIL %s: got %0d active clocks want 0", name, act);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pwm_en = 1'b0;
    initial_cycle = '0;
    initial_duty_cycle = '0;
    initial_update = 1'b0;
    duty_cycle = '0;
    duty_cycle_update = 1'b0;
    up = 1'b0;
    down = 1'b0;
    repeat (2) step();
    check_idle("reset_state");
    rst_n  = 1'b1;
    pwm_en = 1'b1;
    check_quiet("zero_period_low", 20);
    pwm_en = 1'b0;
    step();
  endtask

  task automatic test_basic();
    load(W'(16'h100), W'(16'h10));
    start_run();
    step();
    total++;
    if (pwm !== 1'b1) begin
      bad++;
      $display("FAIL first_high: got %b want 1", pwm);
    end
    repeat (3) push(16, 256);
    drain(1000);
  endtask

  task automatic test_step_up();
    push(16, 256);
    push(17, 256);
    repeat (100) step();
    pulse_up_down(1'b1, 1'b0);
    drain(600);
    push(17, 256);
    push(17, 256);
    repeat (50) step();
    pulse_up_down(1'b1, 1'b1);
    drain(600);
  endtask

  task automatic test_duty_update();
    push(17, 256);
    push(32, 256);
    push(32, 256);
    repeat (30) step();
    duty_cycle = W'(16'h20);
    duty_cycle_update = 1'b1;
    step();
    duty_cycle_update = 1'b0;
    drain(900);
  endtask

  task automatic test_saturation();
    stop_run();
    load(W'(16'h100), W'(16'h100));
    start_run();
    push(256, 256);
    push(256, 256);
    push(255, 256);
    repeat (40) step();
    pulse_up_down(1'b1, 1'b0);
    repeat (260) step();
    pulse_up_down(1'b0, 1'b1);
    drain(900);

    stop_run();
    load(W'(16'h20), W'(0));
    start_run();
    push(0, 32);
    push(0, 32);
    push(1, 32);
    repeat (10) step();
    pulse_up_down(1'b0, 1'b1);
    repeat (32) step();
    pulse_up_down(1'b1, 1'b0);
    drain(200);
  endtask

  task automatic test_disable();
    stop_run();
    load(W'(16'h20), W'(16'h08));
    start_run();
    push(8, 32);
    drain(100);
    repeat (3) step();
    stop_run();
    check_idle("disable_next_clock");
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle("disabled_hold");
    end
    start_run();
    step();
    total++;
    if (pwm !== 1'b1) begin
      bad++;
      $display("FAIL restart_slot0: got %b want 1", pwm);
    end
    push(8, 32);
    push(8, 32);
    drain(100);
  endtask

  task automatic test_reset_mid();
    repeat (5) step();
    mon_on = 1'b0;
    rst_n  = 1'b0;
    step();
    check_idle("reset_mid_run");
    rst_n = 1'b1;
    check_quiet("after_reset_low", 100);
    pwm_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_step_up();
    test_duty_update();
    test_saturation();
    test_disable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
